// File: rtl/goeoqah_ser.sv
// Width-reducing serializer: captures a W_IN-bit word and emits it as W_OUT-bit beats, LSB slice first.
// Optional GOESER_PARITY_EN adds out_par, the registered XOR reduction of out_data.
module goeoqah_ser #(
    parameter  int W_IN   = 120,
    parameter  int W_OUT  = 15,
    localparam int N_BEAT = W_IN / W_OUT,
    localparam int IDX_W  = $clog2(N_BEAT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_OUT-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic [7:0]        frames
`ifdef GOESER_PARITY_EN
    ,
    output logic              out_par
`endif
);

    generate
        if ((W_IN % W_OUT) != 0 || (W_IN / W_OUT) < 2) begin : g_bad_cfg
            $error("goeoqah_ser: W_IN must be a multiple of W_OUT with at least two beats");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             r_state;
    logic [W_IN-1:0]    r_sh;
    logic [IDX_W-1:0]   r_idx;
    logic               r_last;
    logic               r_vld;
    logic [7:0]         r_frames;
`ifdef GOESER_PARITY_EN
    logic               r_par;
`endif

    logic w_take;
    logic w_done;
    logic w_ready;
    logic w_acc;

    assign w_take  = r_vld && out_ready;
    assign w_done  = w_take && r_last;
    // Ready is combinational from out_ready so the next word loads on the same edge the last beat leaves.
    assign w_ready = (r_state == IDLE) || w_done;
    assign w_acc   = in_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sh     <= '0;
            r_idx    <= '0;
            r_last   <= 1'b0;
            r_vld    <= 1'b0;
            r_frames <= 8'd0;
`ifdef GOESER_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            if (w_done) begin
                r_frames <= r_frames + 8'd1;
            end
            if (w_acc) begin
                r_state <= SHIFT;
                r_sh    <= in_data;
                r_idx   <= '0;
                r_last  <= 1'b0;
                r_vld   <= 1'b1;
`ifdef GOESER_PARITY_EN
                r_par   <= ^in_data[W_OUT-1:0];
`endif
            end else if (w_take) begin
                if (r_last) begin
                    r_state <= IDLE;
                    r_vld   <= 1'b0;
                    r_last  <= 1'b0;
                    r_idx   <= '0;
                end else begin
                    r_sh    <= r_sh >> W_OUT;
                    r_idx   <= r_idx + IDX_W'(1);
                    r_last  <= (r_idx == IDX_W'(N_BEAT - 2));
`ifdef GOESER_PARITY_EN
                    // Parity of the beat that becomes current after this shift.
                    r_par   <= ^r_sh[2*W_OUT-1:W_OUT];
`endif
                end
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_vld;
    assign out_data  = r_sh[W_OUT-1:0];
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign frames    = r_frames;
`ifdef GOESER_PARITY_EN
    assign out_par   = r_par;
`endif

endmodule

// File: tb/tb_goeoqah_ser.sv
// Directed bench for goeoqah_ser: reset, single word, backpressure, back-to-back, mid-word reset, frame wrap, parity.
module tb_goeoqah_ser;

    localparam int W_IN  = 120;
    localparam int W_OUT = 15;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [W_IN-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [W_OUT-1:0]  out_data;
    logic [2:0]        out_idx;
    logic              out_last;
    logic [7:0]        frames;
`ifdef GOESER_PARITY_EN
    logic              out_par;
`endif

    int n_cmp;
    int n_err;

    goeoqah_ser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frames    (frames)
`ifdef GOESER_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W_OUT-1:0] beat_of(input logic [W_IN-1:0] w, input int k);
        return w[k*W_OUT +: W_OUT];
    endfunction

    // Spec test word 0123_..._3210 reduced to its low 120 bits.
    localparam logic [W_IN-1:0] D0 = 120'h23_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic [W_IN-1:0] w_ones;
    logic [W_IN-1:0] w_exp;
    logic [W_OUT-1:0] bp_data;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        w_ones = '1;

        // Reset and idle
        repeat (3) tick();
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 128'(in_ready), 128'd1);
        chk("idle_out_valid", 128'(out_valid), 128'd0);
        chk("idle_frames", 128'(frames), 128'd0);
        chk("idle_out_data", 128'(out_data), 128'd0);
        chk("idle_out_idx", 128'(out_idx), 128'd0);
        chk("idle_out_last", 128'(out_last), 128'd0);
`ifdef GOESER_PARITY_EN
        chk("idle_out_par", 128'(out_par), 128'd0);
`endif

        // Single word, out_ready held high
        in_data = D0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data = '1;
        chk("sw_beat0_hand", 128'(out_data), 128'h3210);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("sw_valid%0d", k), 128'(out_valid), 128'd1);
            chk($sformatf("sw_data%0d", k), 128'(out_data), 128'(beat_of(D0, k)));
            chk($sformatf("sw_idx%0d", k), 128'(out_idx), 128'(k));
            chk($sformatf("sw_last%0d", k), 128'(out_last), 128'(k == 7));
            if (k == 1) chk("sw_beat1_hand", 128'(out_data), 128'h6CA8);
            tick();
        end
        chk("sw_frames", 128'(frames), 128'd1);
        chk("sw_done_valid", 128'(out_valid), 128'd0);

        // Backpressure at beat 3
        in_data = D0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("bp_idx3", 128'(out_idx), 128'd3);
        out_ready = 1'b0;
        bp_data = out_data;
        chk("bp_data3", 128'(bp_data), 128'(beat_of(D0, 3)));
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp_hold_data%0d", c), 128'(out_data), 128'(beat_of(D0, 3)));
            chk($sformatf("bp_hold_idx%0d", c), 128'(out_idx), 128'd3);
            chk($sformatf("bp_hold_valid%0d", c), 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_resume_idx", 128'(out_idx), 128'd4);
        chk("bp_resume_data", 128'(out_data), 128'(beat_of(D0, 4)));
        repeat (4) tick();
        chk("bp_frames", 128'(frames), 128'd2);

        // Back-to-back: all-ones then all-zeros, in_valid held high
        in_data = w_ones;
        in_valid = 1'b1;
        tick();
        in_data = '0;
        for (int c = 0; c < 16; c++) begin
            if (c == 15) in_valid = 1'b0;
            w_exp = (c < 8) ? w_ones : '0;
            chk($sformatf("b2b_valid%0d", c), 128'(out_valid), 128'd1);
            chk($sformatf("b2b_data%0d", c), 128'(out_data), 128'(beat_of(w_exp, c % 8)));
            if (c < 15) chk($sformatf("b2b_ready%0d", c), 128'(in_ready), 128'(c == 7));
            tick();
        end
        chk("b2b_end_valid", 128'(out_valid), 128'd0);
        chk("b2b_frames", 128'(frames), 128'd4);

        // Mid-word reset during beat 5
        in_data = D0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("mr_idx5", 128'(out_idx), 128'd5);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 128'(out_valid), 128'd0);
        chk("mr_data", 128'(out_data), 128'd0);
        chk("mr_idx", 128'(out_idx), 128'd0);
        chk("mr_last", 128'(out_last), 128'd0);
        chk("mr_frames", 128'(frames), 128'd0);
        chk("mr_in_ready", 128'(in_ready), 128'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_post_frames", 128'(frames), 128'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mr_restart_idx", 128'(out_idx), 128'd0);
        chk("mr_restart_data", 128'(out_data), 128'(beat_of(D0, 0)));
        repeat (8) tick();
        chk("mr_restart_frames", 128'(frames), 128'd1);

        // Frame counter wrap: stream continuously
        in_data = w_ones;
        in_valid = 1'b1;
        tick();
        repeat (8 * 254) tick();
        chk("wrap_255", 128'(frames), 128'd255);
        repeat (8) tick();
        chk("wrap_0", 128'(frames), 128'd0);
        in_valid = 1'b0;
        repeat (8) tick();
        chk("wrap_1", 128'(frames), 128'd1);
        chk("wrap_idle", 128'(out_valid), 128'd0);

`ifdef GOESER_PARITY_EN
        // Parity: beat0 = 0x0007 (odd count), beat1 = 0x0003 (even count)
        in_data = '0;
        in_data[14:0] = 15'h0007;
        in_data[29:15] = 15'h0003;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("par_beat0", 128'(out_par), 128'd1);
        tick();
        chk("par_beat1_data", 128'(out_data), 128'h0003);
        chk("par_beat1", 128'(out_par), 128'd0);
        repeat (7) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
